// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store front end for a word-addressed,
// whole-word-write data memory. Sub-word stores are done as read-modify-write;
// loads are returned sign- or zero-extended.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When it is defined, misaligned
// half/word requests are answered with resp_err=1 and touch no memory.
// When it is undefined, resp_err stays 0 and the low address bits that would
// make the access misaligned are ignored.
module load_store_unit #(
    parameter int MEM_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    // Address bits kept: word index plus the two byte-offset bits.
    localparam int AW    = IDX_W + 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_STORE  = 3'd2;
    localparam logic [2:0] S_RMW_RD = 3'd3;
    localparam logic [2:0] S_RMW_WR = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    logic [2:0]    state_q, state_d;
    logic          write_q, write_d;
    logic [1:0]    size_q, size_d;
    logic          unsigned_q, unsigned_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   merge_q, merge_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic          resp_err_q, resp_err_d;

    logic          misalign;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_ext;
    logic [31:0]   store_src;
    logic [3:0]    lane_en;
    logic [31:0]   merged_word;

    // Address bits above the wrapped word index are deliberately ignored.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:AW];

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = {{(32 - AW){1'b0}}, addr_q[AW-1:2], 2'b00};
    // Gated by rst_n so a reset asserted during a write cycle suppresses it.
    assign mem_write  = rst_n & write_q &
                        ((state_q == S_STORE) || (state_q == S_RMW_WR));
    assign mem_wdata  = (state_q == S_RMW_WR) ? merged_word : wdata_q;

    // Pick the addressed lane out of the read word and extend it.
    always_comb begin
        ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   ld_ext = unsigned_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = unsigned_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    // Replicate store data across lanes so any target lane can take it directly.
    always_comb begin
        case (size_q)
            2'b00:   store_src = {4{wdata_q[7:0]}};
            2'b01:   store_src = {2{wdata_q[15:0]}};
            default: store_src = wdata_q;
        endcase
    end

    // Per-lane merge: target lanes take new data, the rest keep the read word.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign lane_en[gi] = size_q[1] |
                                 (size_q[0] ? (addr_q[1] == LANE[1]) : (addr_q[1:0] == LANE));
            assign merged_word[8*gi +: 8] = lane_en[gi] ? store_src[8*gi +: 8]
                                                        : merge_q[8*gi +: 8];
        end
    endgenerate

    // Next-state and datapath register updates for the request sequencer.
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        merge_d      = merge_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d    = req_write;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    addr_d     = req_addr[AW-1:0];
                    wdata_d    = req_wdata;
                    if (misalign) begin
                        state_d      = S_RESP;
                        resp_rdata_d = 32'h0;
                        resp_err_d   = 1'b1;
                    end else if (!req_write) begin
                        state_d = S_LOAD;
                    end else if (req_size[1]) begin
                        state_d = S_STORE;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_LOAD: begin
                resp_rdata_d = ld_ext;
                resp_err_d   = 1'b0;
                state_d      = S_RESP;
            end
            S_STORE: begin
                resp_rdata_d = 32'h0;
                resp_err_d   = 1'b0;
                state_d      = S_RESP;
            end
            S_RMW_RD: begin
                merge_d = mem_rdata;
                state_d = S_RMW_WR;
            end
            S_RMW_WR: begin
                resp_rdata_d = 32'h0;
                resp_err_d   = 1'b0;
                state_d      = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and register update; reset abandons any request in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            merge_q      <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            merge_q      <= merge_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed tests for load_store_unit against a bench-side
// 128-word memory. Expected values are hand-computed from the initial memory
// image and the sequence of stores. Honours LSU_MISALIGN_TRAP_EN if defined.
`timescale 1ns/1ps
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:127];
    logic        tb_wr_en;
    logic [6:0]  tb_wr_idx;
    logic [31:0] tb_wr_data;
    logic        tb_unused_addr;

    int tests_run;
    int tests_failed;

    load_store_unit #(.MEM_WORDS(128)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench memory: combinational read, write on the rising edge.
    assign mem_rdata      = mem[mem_addr[8:2]];
    assign tb_unused_addr = ^mem_addr[31:9];
    always @(posedge clk) begin
        if (tb_wr_en)
            mem[tb_wr_idx] <= tb_wr_data;
        else if (mem_write)
            mem[mem_addr[8:2]] <= mem_wdata;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic poke(input logic [6:0] idx, input logic [31:0] data);
        @(negedge clk);
        tb_wr_en   = 1'b1;
        tb_wr_idx  = idx;
        tb_wr_data = data;
        @(posedge clk);
        #1 tb_wr_en = 1'b0;
    endtask

    // Issue one request, then observe 6 cycles. Cycle 1 is the first cycle
    // after the accept edge. rcyc = -1 flags more than one response pulse.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int rcyc, output logic [31:0] rdata, output logic err,
                          output int wcyc, output int wcnt);
        @(negedge clk);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rcyc = 0; rdata = 32'h0; err = 1'b0; wcyc = 0; wcnt = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (mem_write === 1'b1) begin
                wcnt++;
                wcyc = c;
            end
            if (resp_valid === 1'b1) begin
                if (rcyc == 0) begin
                    rcyc  = c;
                    rdata = resp_rdata;
                    err   = resp_err;
                end else begin
                    rcyc = -1;
                end
            end
        end
        $display("[TB] %s size=%0d uns=%0d addr=%h wdata=%h -> resp@%0d rdata=%h err=%0d writes=%0d@%0d",
                 wr ? "store" : "load ", sz, uns, a, wd, rcyc, rdata, err, wcnt, wcyc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        poke(7'd0, 32'h0000000F);
        poke(7'd1, 32'h00000014);
        poke(7'd2, 32'h11223344);
        poke(7'd3, 32'h5A5A5A5A);
        poke(7'd4, 32'hFFFFFFFF);
        poke(7'd5, 32'h80017F42);
        @(negedge clk);
        tests_run++;
        if (mem_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mem_write: got %b required 0", mem_write);
        end
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_req_ready: got %b required 1", req_ready);
        end
        tests_run++;
        if (resp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_resp_valid: got %b required 0", resp_valid);
        end
        tests_run++;
        if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_resp_data: got rdata=%h err=%b required 00000000/0", resp_rdata, resp_err);
        end
        $display("[TB] reset released");
    endtask

    task automatic test_loads();
        logic [1:0]  sz_t [11] = '{2'd2, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd2};
        logic        un_t [11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] a_t  [11] = '{32'h04, 32'h11, 32'h11, 32'h12, 32'h17, 32'h14, 32'h16,
                                   32'h16, 32'h15, 32'h14, 32'h204};
        logic [31:0] e_t  [11] = '{32'h00000014, 32'hFFFFFFFF, 32'h000000FF, 32'h0000FFFF,
                                   32'hFFFFFF80, 32'h00007F42, 32'hFFFF8001, 32'h00000001,
                                   32'h0000007F, 32'h80017F42, 32'h00000014};
        int rcyc, wcyc, wcnt;
        logic [31:0] rd;
        logic er;
        for (int i = 0; i < 11; i++) begin
            do_req(1'b0, sz_t[i], un_t[i], a_t[i], 32'h0, rcyc, rd, er, wcyc, wcnt);
            tests_run++;
            if (rcyc !== 2 || rd !== e_t[i] || er !== 1'b0 || wcnt !== 0) begin
                tests_failed++;
                $display("FAIL load_%0d: got resp@%0d rdata=%h err=%b writes=%0d required resp@2 rdata=%h err=0 writes=0",
                         i, rcyc, rd, er, wcnt, e_t[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int nresp = 0, c1 = 0, c2 = 0;
        logic [31:0] d1 = 32'h0, d2 = 32'h0;
        logic busy_seen = 1'b0;
        logic pend = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h04; req_wdata = 32'h0;
        @(posedge clk);
        #1 req_addr = 32'h10;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (pend) begin
                req_valid = 1'b0;
                pend = 1'b0;
            end
            if (c == 1 && req_ready === 1'b0) busy_seen = 1'b1;
            if (resp_valid === 1'b1) begin
                nresp++;
                if (nresp == 1) begin c1 = c; d1 = resp_rdata; end
                else if (nresp == 2) begin c2 = c; d2 = resp_rdata; end
            end
            if (req_valid && req_ready === 1'b1) pend = 1'b1;
        end
        req_valid = 1'b0;
        $display("[TB] back-to-back loads -> resp@%0d %h, resp@%0d %h", c1, d1, c2, d2);
        tests_run++;
        if (busy_seen !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_busy: got req_ready=1 in cycle 1 required 0");
        end
        tests_run++;
        if (nresp !== 2 || c1 !== 2 || d1 !== 32'h00000014) begin
            tests_failed++;
            $display("FAIL b2b_first: got n=%0d resp@%0d rdata=%h required n=2 resp@2 rdata=00000014", nresp, c1, d1);
        end
        tests_run++;
        if (c2 !== 5 || d2 !== 32'hFFFFFFFF) begin
            tests_failed++;
            $display("FAIL b2b_second: got resp@%0d rdata=%h required resp@5 rdata=ffffffff", c2, d2);
        end
    endtask

    task automatic test_stores();
        logic [1:0]  sz_t [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd3};
        logic [31:0] a_t  [6] = '{32'h01, 32'h06, 32'h04, 32'h20B, 32'h08, 32'h08};
        logic [31:0] w_t  [6] = '{32'hFFFFFFAB, 32'h55551234, 32'hDEADBEEF, 32'h000000CC,
                                  32'h0000BEEF, 32'h01020304};
        logic [6:0]  i_t  [6] = '{7'd0, 7'd1, 7'd1, 7'd2, 7'd2, 7'd2};
        logic [31:0] m_t  [6] = '{32'h0000AB0F, 32'h12340014, 32'hDEADBEEF, 32'hCC223344,
                                  32'hCC22BEEF, 32'h01020304};
        int          r_t  [6] = '{3, 3, 2, 3, 3, 2};
        int rcyc, wcyc, wcnt;
        logic [31:0] rd;
        logic er;
        for (int i = 0; i < 6; i++) begin
            do_req(1'b1, sz_t[i], 1'b0, a_t[i], w_t[i], rcyc, rd, er, wcyc, wcnt);
            tests_run++;
            if (rcyc !== r_t[i] || wcyc !== r_t[i] - 1 || wcnt !== 1 || rd !== 32'h0 ||
                er !== 1'b0 || mem[i_t[i]] !== m_t[i]) begin
                tests_failed++;
                $display("FAIL store_%0d: got resp@%0d writes=%0d@%0d rdata=%h err=%b word=%h required resp@%0d writes=1@%0d rdata=0 err=0 word=%h",
                         i, rcyc, wcnt, wcyc, rd, er, mem[i_t[i]], r_t[i], r_t[i] - 1, m_t[i]);
            end
        end
    endtask

    task automatic test_misalign();
        logic        w_t  [3] = '{1'b0, 1'b0, 1'b1};
        logic [1:0]  sz_t [3] = '{2'd2, 2'd1, 2'd1};
        logic [31:0] a_t  [3] = '{32'h02, 32'h13, 32'h05};
`ifdef LSU_MISALIGN_TRAP_EN
        int          r_t  [3] = '{1, 1, 1};
        logic [31:0] d_t  [3] = '{32'h0, 32'h0, 32'h0};
        logic        e_t  [3] = '{1'b1, 1'b1, 1'b1};
        int          n_t  [3] = '{0, 0, 0};
        logic [31:0] word1_exp = 32'hDEADBEEF;
`else
        int          r_t  [3] = '{2, 2, 3};
        logic [31:0] d_t  [3] = '{32'h0000AB0F, 32'h0000FFFF, 32'h0};
        logic        e_t  [3] = '{1'b0, 1'b0, 1'b0};
        int          n_t  [3] = '{0, 0, 1};
        logic [31:0] word1_exp = 32'hDEAD7777;
`endif
        int rcyc, wcyc, wcnt;
        logic [31:0] rd;
        logic er;
        for (int i = 0; i < 3; i++) begin
            do_req(w_t[i], sz_t[i], 1'b1, a_t[i], 32'h00007777, rcyc, rd, er, wcyc, wcnt);
            tests_run++;
            if (rcyc !== r_t[i] || rd !== d_t[i] || er !== e_t[i] || wcnt !== n_t[i]) begin
                tests_failed++;
                $display("FAIL misalign_%0d: got resp@%0d rdata=%h err=%b writes=%0d required resp@%0d rdata=%h err=%b writes=%0d",
                         i, rcyc, rd, er, wcnt, r_t[i], d_t[i], e_t[i], n_t[i]);
            end
        end
        tests_run++;
        if (mem[1] !== word1_exp) begin
            tests_failed++;
            $display("FAIL misalign_word1: got %h required %h", mem[1], word1_exp);
        end
    endtask

    task automatic test_reset_in_rmw_rd();
        int rcyc, wcyc, wcnt;
        logic [31:0] rd;
        logic er;
        logic bad_write = 1'b0, bad_resp = 1'b0, ready_ok = 1'b0;
        // Leave a nonzero load result behind so the reset clear is visible.
        do_req(1'b0, 2'd2, 1'b0, 32'h04, 32'h0, rcyc, rd, er, wcyc, wcnt);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0C; req_wdata = 32'h00000011;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1 && req_ready === 1'b1) ready_ok = 1'b1;
            if (mem_write !== 1'b0) bad_write = 1'b1;
            if (resp_valid !== 1'b0) bad_resp = 1'b1;
        end
        $display("[TB] byte store aborted by reset in read phase -> word3=%h", mem[3]);
        tests_run++;
        if (ready_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_rd_ready: got req_ready=0 after release required 1");
        end
        tests_run++;
        if (bad_write !== 1'b0 || bad_resp !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_rd_quiet: got write=%b resp=%b required 0/0", bad_write, bad_resp);
        end
        tests_run++;
        if (mem[3] !== 32'h5A5A5A5A || resp_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_rd_state: got word3=%h rdata=%h required 5a5a5a5a/00000000", mem[3], resp_rdata);
        end
    endtask

    task automatic test_reset_in_rmw_wr();
        logic bad_resp = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0E; req_wdata = 32'h00000022;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (mem_write !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_wr_pre: got mem_write=%b in write cycle required 1", mem_write);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (mem_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_wr_gate: got mem_write=%b with rst_n low required 0", mem_write);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) bad_resp = 1'b1;
        end
        $display("[TB] byte store aborted by reset in write phase -> word3=%h", mem[3]);
        tests_run++;
        if (bad_resp !== 1'b0 || mem[3] !== 32'h5A5A5A5A) begin
            tests_failed++;
            $display("FAIL rst_wr_state: got resp=%b word3=%h required 0/5a5a5a5a", bad_resp, mem[3]);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        tb_wr_en     = 1'b0;
        tb_wr_idx    = 7'd0;
        tb_wr_data   = 32'h0;
        test_reset();
        test_loads();
        test_back_to_back();
        test_stores();
        test_misalign();
        test_reset_in_rmw_rd();
        test_reset_in_rmw_wr();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
